multi_servo_driver: RTL and testbench

Parametrised N-channel servo PWM generator; successor to the single-channel servo driver. Shares one frame counter across all channels, accepts per-channel angle writes over a simple write port, and applies new angles only at frame boundaries so that no channel ever emits a runt or stretched pulse. It sits between the MCU-facing register interface and the servo output pins.

---
 rtl/multi_servo_driver_if.sv | 14 +
 rtl/multi_servo_driver.sv | 125 ++++++++++++
 tb/tb_multi_servo_driver.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/multi_servo_driver_if.sv
// Angle write port shared between the register front-end (master) and the servo driver (slave).
interface multi_servo_driver_if #(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned ANGLE_W = 8
);
    localparam int unsigned ChW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic               wr_en;
    logic [ChW-1:0]     wr_ch;
    logic [ANGLE_W-1:0] wr_angle;

    modport master (output wr_en, wr_ch, wr_angle);
    modport slave  (input  wr_en, wr_ch, wr_angle);
endinterface

// File: rtl/multi_servo_driver.sv
// N-channel servo PWM generator sharing one frame counter; angles and enables apply at frame
// boundaries only. Optional macro SLEW_LIMIT_EN limits angle change per frame to SLEW_STEP.
module multi_servo_driver #(
    parameter int unsigned NUM_CH       = 4,
    parameter int unsigned ANGLE_W      = 8,
    parameter int unsigned FRAME_CYCLES = 480000,
    parameter int unsigned MIN_PULSE    = 24000,
    parameter int unsigned STEP_CYCLES  = 133,
    parameter int unsigned MAX_ANGLE    = 180,
    parameter int unsigned CENTER_ANGLE = 90,
    parameter int unsigned SLEW_STEP    = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    multi_servo_driver_if.slave wr_if,
    input  logic [NUM_CH-1:0]   ch_enable_i,
    output logic [NUM_CH-1:0]   servo_signal_o,
    output logic                frame_start_o
);
    typedef logic [ANGLE_W-1:0] angle_t;

    logic              run_q, run_d;
    logic [31:0]       cnt_q, cnt_d;
    logic              frame_start_q, frame_start_d;
    logic [NUM_CH-1:0] en_q, en_d;
    logic [NUM_CH-1:0] servo_q, servo_d;
    angle_t            target_q [NUM_CH];
    angle_t            target_d [NUM_CH];
    angle_t            active_q [NUM_CH];
    angle_t            active_d [NUM_CH];
    logic [31:0]       pulse_len [NUM_CH];
    angle_t            wr_angle_clamped;
    logic              wrap;

`ifdef SLEW_LIMIT_EN
    function automatic angle_t slew_toward(angle_t cur, angle_t tgt);
        logic [31:0] c;
        logic [31:0] t;
        c = 32'(cur);
        t = 32'(tgt);
        if (t > c + SLEW_STEP) begin
            return angle_t'(c + SLEW_STEP);
        end else if (t + SLEW_STEP < c) begin
            return angle_t'(c - SLEW_STEP);
        end
        return tgt;
    endfunction
`else
    logic unused_slew_step;
    assign unused_slew_step = ^SLEW_STEP;
`endif

    assign wrap = run_q && (cnt_q == 32'(FRAME_CYCLES - 1));

    always_comb begin
        wr_angle_clamped = wr_if.wr_angle;
        if (32'(wr_if.wr_angle) > MAX_ANGLE) begin
            wr_angle_clamped = angle_t'(MAX_ANGLE);
        end
    end

    // run_q holds the counter at 0 for the first edge after reset so frame 1 starts with cnt=0.
    always_comb begin
        run_d         = 1'b1;
        cnt_d         = cnt_q + 32'd1;
        frame_start_d = 1'b0;
        en_d          = en_q;
        active_d      = active_q;
        target_d      = target_q;

        if (!run_q || wrap) begin
            cnt_d         = '0;
            frame_start_d = 1'b1;
        end

        if (wrap) begin
            en_d = ch_enable_i;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
`ifdef SLEW_LIMIT_EN
                active_d[i] = slew_toward(active_q[i], target_q[i]);
`else
                active_d[i] = target_q[i];
`endif
            end
        end

        // Out-of-range channel indices match no entry and are dropped.
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (wr_if.wr_en && (32'(wr_if.wr_ch) == i)) begin
                target_d[i] = wr_angle_clamped;
            end
        end

        // Outputs are computed from next-state values so the flops line up with cnt_q.
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            pulse_len[i] = MIN_PULSE + 32'(active_d[i]) * STEP_CYCLES;
            servo_d[i]   = en_d[i] && (cnt_d < pulse_len[i]);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            run_q         <= 1'b0;
            cnt_q         <= '0;
            frame_start_q <= 1'b0;
            en_q          <= '0;
            servo_q       <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                target_q[i] <= angle_t'(CENTER_ANGLE);
                active_q[i] <= angle_t'(CENTER_ANGLE);
            end
        end else begin
            run_q         <= run_d;
            cnt_q         <= cnt_d;
            frame_start_q <= frame_start_d;
            en_q          <= en_d;
            servo_q       <= servo_d;
            target_q      <= target_d;
            active_q      <= active_d;
        end
    end

    assign servo_signal_o = servo_q;
    assign frame_start_o  = frame_start_q;
endmodule

// File: tb/tb_multi_servo_driver.sv
// Bench for multi_servo_driver: frame-level reference model, directed scenarios, random writes.
module tb_multi_servo_driver;
    localparam int unsigned NUM_CH       = 5;
    localparam int unsigned ANGLE_W      = 8;
    localparam int unsigned FRAME_CYCLES = 1200;
    localparam int unsigned MIN_PULSE    = 100;
    localparam int unsigned STEP_CYCLES  = 5;
    localparam int unsigned MAX_ANGLE    = 180;
    localparam int unsigned CENTER_ANGLE = 90;
    localparam int unsigned SLEW_STEP    = 4;

    logic              clk_i  = 1'b0;
    logic              rst_ni = 1'b0;
    logic [NUM_CH-1:0] ch_enable;
    logic [NUM_CH-1:0] servo_signal;
    logic              frame_start;

    multi_servo_driver_if #(.NUM_CH(NUM_CH), .ANGLE_W(ANGLE_W)) wr_if ();

    multi_servo_driver #(
        .NUM_CH       (NUM_CH),
        .ANGLE_W      (ANGLE_W),
        .FRAME_CYCLES (FRAME_CYCLES),
        .MIN_PULSE    (MIN_PULSE),
        .STEP_CYCLES  (STEP_CYCLES),
        .MAX_ANGLE    (MAX_ANGLE),
        .CENTER_ANGLE (CENTER_ANGLE),
        .SLEW_STEP    (SLEW_STEP)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .wr_if          (wr_if),
        .ch_enable_i    (ch_enable),
        .servo_signal_o (servo_signal),
        .frame_start_o  (frame_start)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    // Reference model: frame position, requested angles, angles in force, enables in force.
    bit m_run;
    int m_cnt;
    bit m_fs;
    int m_target [NUM_CH];
    int m_active [NUM_CH];
    bit m_en     [NUM_CH];

    function automatic int plen(input int angle);
        return MIN_PULSE + angle * STEP_CYCLES;
    endfunction

    function automatic int next_angle(input int cur, input int tgt);
`ifdef SLEW_LIMIT_EN
        if (tgt > cur + SLEW_STEP) return cur + SLEW_STEP;
        if (tgt < cur - SLEW_STEP) return cur - SLEW_STEP;
`endif
        return tgt;
    endfunction

    task automatic model_reset();
        m_run = 0;
        m_cnt = 0;
        m_fs  = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            m_target[i] = CENTER_ANGLE;
            m_active[i] = CENTER_ANGLE;
            m_en[i]     = 0;
        end
    endtask

    task automatic model_edge();
        int a;
        if (!m_run) begin
            m_run = 1;
            m_cnt = 0;
            m_fs  = 1;
        end else if (m_cnt == FRAME_CYCLES - 1) begin
            for (int i = 0; i < NUM_CH; i++) begin
                m_active[i] = next_angle(m_active[i], m_target[i]);
                m_en[i]     = ch_enable[i];
            end
            m_cnt = 0;
            m_fs  = 1;
        end else begin
            m_cnt++;
            m_fs = 0;
        end
        if (wr_if.wr_en && int'(wr_if.wr_ch) < NUM_CH) begin
            a = int'(wr_if.wr_angle);
            m_target[int'(wr_if.wr_ch)] = (a > MAX_ANGLE) ? MAX_ANGLE : a;
        end
    endtask

    function automatic logic [NUM_CH-1:0] model_servo();
        logic [NUM_CH-1:0] s;
        for (int i = 0; i < NUM_CH; i++) s[i] = m_en[i] && (m_cnt < plen(m_active[i]));
        return s;
    endfunction

    // One clock: inputs are already set; model follows the edge, outputs checked at negedge.
    task automatic step();
        @(posedge clk_i);
        if (rst_ni) model_edge();
        @(negedge clk_i);
        check("frame_start", frame_start, m_fs);
        check("servo", servo_signal, model_servo());
        wr_if.wr_en = 1'b0;
    endtask

    task automatic write(input int ch, input int angle);
        wr_if.wr_en    = 1'b1;
        wr_if.wr_ch    = ch[2:0];
        wr_if.wr_angle = angle[ANGLE_W-1:0];
        step();
    endtask

    // Advance until the next edge starts a new frame.
    task automatic align();
        int n = 0;
        while (m_run && m_cnt != FRAME_CYCLES - 1 && n <= FRAME_CYCLES) begin
            step();
            n++;
        end
        if (n > FRAME_CYCLES) check("align_timeout", 0, 1);
    endtask

    task automatic expect_frame(input string tag, input int l0, input int l1, input int l2,
                                input int l3, input int l4);
        int lens [NUM_CH];
        int want [NUM_CH];
        int fs_cnt;
        want = '{l0, l1, l2, l3, l4};
        align();
        lens   = '{default: 0};
        fs_cnt = 0;
        repeat (FRAME_CYCLES) begin
            step();
            for (int i = 0; i < NUM_CH; i++) lens[i] += int'(servo_signal[i]);
            fs_cnt += int'(frame_start);
        end
        for (int i = 0; i < NUM_CH; i++) check($sformatf("%s_len%0d", tag, i), lens[i], want[i]);
        check({tag, "_fs_count"}, fs_cnt, 1);
    endtask

    initial begin
        int ang;
        wr_if.wr_en    = 1'b0;
        wr_if.wr_ch    = '0;
        wr_if.wr_angle = '0;
        ch_enable      = '0;
        model_reset();
        repeat (3) step();

        // Frame 1 dark, then centred pulses on every channel.
        ch_enable = '1;
        rst_ni    = 1'b1;
        expect_frame("f1", 0, 0, 0, 0, 0);
        expect_frame("f2", plen(90), plen(90), plen(90), plen(90), plen(90));
        expect_frame("f3", plen(90), plen(90), plen(90), plen(90), plen(90));

        // Mid-frame writes including a clamped angle.
        repeat (300) step();
        write(0, 0);
        write(1, 180);
        write(2, 200);
        expect_frame("wr", plen(0), plen(180), plen(180), plen(90), plen(90));

        // A write in the last cycle of a frame misses that boundary.
        repeat (10) step();
        write(0, 90);
        align();
        wr_if.wr_en    = 1'b1;
        wr_if.wr_ch    = 3'd0;
        wr_if.wr_angle = 8'd0;
        expect_frame("coll", plen(90), plen(180), plen(180), plen(90), plen(90));
        expect_frame("coll2", plen(0), plen(180), plen(180), plen(90), plen(90));

        // Out-of-range channel indices are ignored.
        repeat (100) step();
        write(5, 0);
        write(6, 0);
        write(7, 0);
        expect_frame("inval", plen(0), plen(180), plen(180), plen(90), plen(90));

        // Disable ch1 mid-pulse: current pulse completes, next frame dark.
        repeat (200) step();
        ch_enable[1] = 1'b0;
        expect_frame("dis", plen(0), 0, plen(180), plen(90), plen(90));
        ch_enable = '1;
        expect_frame("reen", plen(0), plen(180), plen(180), plen(90), plen(90));

        repeat (50) step();
        write(3, 180);
`ifdef SLEW_LIMIT_EN
        for (int k = 1; k <= 24; k++) begin
            ang = (90 + 4 * k > 180) ? 180 : 90 + 4 * k;
            expect_frame($sformatf("slew%0d", k), plen(0), plen(180), plen(180), plen(ang),
                         plen(90));
        end
`else
        ang = 180;
        expect_frame("jump1", plen(0), plen(180), plen(180), plen(ang), plen(90));
        expect_frame("jump2", plen(0), plen(180), plen(180), plen(ang), plen(90));
`endif

        // Reset asserted while every channel is high.
        align();
        repeat (91) step();
        check("pre_rst_high", servo_signal, {NUM_CH{1'b1}});
        #2 rst_ni = 1'b0;
        #1;
        check("rst_async_servo", servo_signal, '0);
        check("rst_async_fs", frame_start, 0);
        model_reset();
        repeat (2) step();
        rst_ni = 1'b1;
        expect_frame("rf1", 0, 0, 0, 0, 0);
        expect_frame("rf2", plen(90), plen(90), plen(90), plen(90), plen(90));

        // Random writes and enable changes, checked every cycle against the model.
        repeat (20 * FRAME_CYCLES) begin
            if ($urandom_range(0, 2999) == 0) ch_enable = NUM_CH'($urandom);
            if ($urandom_range(0, 49) == 0) begin
                write(int'($urandom_range(0, 7)), int'($urandom_range(0, 255)));
            end else begin
                step();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
